// File: rtl/car_position_controller.sv
// car_position_controller: per-frame player car state (x, row, speed, scroll) with crash/respawn.
// Optional feature macro CAR_BLINK_EN: blink car_visible while in CRASH and RESPAWN.
module car_position_controller #(
   parameter logic [7:0]  X_MIN        = 8'd0,
   parameter logic [7:0]  X_MAX        = 8'd239,
   parameter logic [7:0]  X_START      = 8'd120,
   parameter logic [9:0]  CAR_Y        = 10'd400,
   parameter logic [7:0]  STEER_STEP   = 8'd2,
   parameter logic [2:0]  MAX_SPEED    = 3'd7,
   parameter int unsigned ACCEL_FRAMES = 8,
   parameter int unsigned CRASH_FRAMES = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_accel,
   input  logic       crash,
   output logic [7:0] car_position_x,
   output logic [9:0] car_position_y,
   output logic [2:0] speed,
   output logic [9:0] road_offset,
   output logic       car_visible,
   output logic       update
);

   localparam int unsigned CNT_W = $clog2(ACCEL_FRAMES);
   localparam int unsigned TMR_W = $clog2(CRASH_FRAMES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCEL_FRAMES - 1);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(CRASH_FRAMES - 1);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_CRASH   = 2'd1,
      ST_RESPAWN = 2'd2
   } state_t;

   state_t           state_r, state_next_s;
   logic [7:0]       x_r, x_next_s;
   logic [9:0]       y_r;
   logic [2:0]       speed_r, speed_next_s;
   logic [9:0]       offset_r, offset_next_s;
   logic [CNT_W-1:0] cnt_r, cnt_next_s;
   logic [TMR_W-1:0] timer_r, timer_next_s;
   logic             pending_r, pending_next_s;
   logic             update_r;
   logic             crash_hit_s;
   logic             wrap_s;
   logic [8:0]       x_left9_s, x_right9_s;
   logic [7:0]       x_left_s, x_right_s, x_respawn_s;

   assign crash_hit_s = pending_r | crash;
   assign wrap_s      = (cnt_r == CNT_LAST);

   // Lateral move candidates, clamped through a 9-bit intermediate so x never wraps
   always_comb begin
      x_left9_s  = {1'b0, x_r} - {1'b0, STEER_STEP};
      x_right9_s = {1'b0, x_r} + {1'b0, STEER_STEP};
      if ({1'b0, x_r} < ({1'b0, X_MIN} + {1'b0, STEER_STEP})) begin
         x_left_s = X_MIN;
      end else begin
         x_left_s = x_left9_s[7:0];
      end
      if (x_right9_s > {1'b0, X_MAX}) begin
         x_right_s = X_MAX;
      end else begin
         x_right_s = x_right9_s[7:0];
      end
   end

   // Respawn glide: step toward X_START by at most STEER_STEP
   always_comb begin
      x_respawn_s = X_START;
      if (x_r > X_START) begin
         if ((x_r - X_START) > STEER_STEP) begin
            x_respawn_s = x_r - STEER_STEP;
         end else begin
            x_respawn_s = X_START;
         end
      end else if (x_r < X_START) begin
         if ((X_START - x_r) > STEER_STEP) begin
            x_respawn_s = x_r + STEER_STEP;
         end else begin
            x_respawn_s = X_START;
         end
      end else begin
         x_respawn_s = X_START;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_RUN;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic, evaluated only on frame ticks
   always_comb begin
      state_next_s = state_r;
      if (frame_tick) begin
         case (state_r)
            ST_RUN: begin
               if (crash_hit_s) begin
                  state_next_s = ST_CRASH;
               end else begin
                  state_next_s = ST_RUN;
               end
            end
            ST_CRASH: begin
               if (timer_r == {TMR_W{1'b0}}) begin
                  state_next_s = ST_RESPAWN;
               end else begin
                  state_next_s = ST_CRASH;
               end
            end
            ST_RESPAWN: begin
               if (x_respawn_s == X_START) begin
                  state_next_s = ST_RUN;
               end else begin
                  state_next_s = ST_RESPAWN;
               end
            end
            default: state_next_s = ST_RUN;
         endcase
      end else begin
         state_next_s = state_r;
      end
   end

   // Per-frame datapath updates; between ticks only a crash report is latched
   always_comb begin
      x_next_s       = x_r;
      speed_next_s   = speed_r;
      offset_next_s  = offset_r;
      cnt_next_s     = cnt_r;
      timer_next_s   = timer_r;
      pending_next_s = pending_r;
      if (frame_tick) begin
         cnt_next_s     = wrap_s ? {CNT_W{1'b0}} : (cnt_r + CNT_W'(1));
         pending_next_s = 1'b0;
         case (state_r)
            ST_RUN: begin
               if (crash_hit_s) begin
                  speed_next_s = 3'd0;
                  timer_next_s = TMR_LOAD;
               end else begin
                  if (wrap_s) begin
                     if (btn_accel) begin
                        speed_next_s = (speed_r == MAX_SPEED) ? speed_r : (speed_r + 3'd1);
                     end else begin
                        speed_next_s = (speed_r == 3'd0) ? speed_r : (speed_r - 3'd1);
                     end
                  end else begin
                     speed_next_s = speed_r;
                  end
                  // Steering and scroll both use the speed held before this tick
                  if ((speed_r != 3'd0) && btn_left && !btn_right) begin
                     x_next_s = x_left_s;
                  end else if ((speed_r != 3'd0) && btn_right && !btn_left) begin
                     x_next_s = x_right_s;
                  end else begin
                     x_next_s = x_r;
                  end
                  offset_next_s = offset_r + {7'd0, speed_r};
               end
            end
            ST_CRASH: begin
               speed_next_s = 3'd0;
               if (timer_r != {TMR_W{1'b0}}) begin
                  timer_next_s = timer_r - TMR_W'(1);
               end else begin
                  timer_next_s = timer_r;
               end
            end
            ST_RESPAWN: begin
               speed_next_s = 3'd0;
               x_next_s     = x_respawn_s;
            end
            default: begin
               speed_next_s = 3'd0;
            end
         endcase
      end else begin
         pending_next_s = (state_r == ST_RUN) ? (pending_r | crash) : 1'b0;
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         x_r       <= X_START;
         y_r       <= CAR_Y;
         speed_r   <= 3'd0;
         offset_r  <= 10'd0;
         cnt_r     <= {CNT_W{1'b0}};
         timer_r   <= {TMR_W{1'b0}};
         pending_r <= 1'b0;
         update_r  <= 1'b0;
      end else begin
         x_r       <= x_next_s;
         y_r       <= CAR_Y;
         speed_r   <= speed_next_s;
         offset_r  <= offset_next_s;
         cnt_r     <= cnt_next_s;
         timer_r   <= timer_next_s;
         pending_r <= pending_next_s;
         update_r  <= frame_tick;
      end
   end

`ifdef CAR_BLINK_EN
   logic vis_r, vis_next_s;

   // Blink while crashed or respawning; solid again as soon as RUN resumes
   always_comb begin
      vis_next_s = vis_r;
      if (frame_tick) begin
         if (state_next_s == ST_RUN) begin
            vis_next_s = 1'b1;
         end else if ((state_r != ST_RUN) && (cnt_r[1:0] == 2'b11)) begin
            vis_next_s = ~vis_r;
         end else begin
            vis_next_s = vis_r;
         end
      end else begin
         vis_next_s = vis_r;
      end
   end

   // Visibility register
   always_ff @(posedge clk) begin
      if (reset) begin
         vis_r <= 1'b1;
      end else begin
         vis_r <= vis_next_s;
      end
   end

   assign car_visible = vis_r;
`else
   assign car_visible = 1'b1;
`endif

   assign car_position_x = x_r;
   assign car_position_y = y_r;
   assign speed          = speed_r;
   assign road_offset    = offset_r;
   assign update         = update_r;

endmodule

// File: tb/tb_car_position_controller.sv
// Self-checking bench for car_position_controller: directed scenarios plus random
// stimulus against an integer-arithmetic reference model of the frame rules.
module tb_car_position_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       frame_tick = 1'b0;
   logic       btn_left = 1'b0;
   logic       btn_right = 1'b0;
   logic       btn_accel = 1'b0;
   logic       crash = 1'b0;
   logic [7:0] car_position_x;
   logic [9:0] car_position_y;
   logic [2:0] speed;
   logic [9:0] road_offset;
   logic       car_visible;
   logic       update;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   car_position_controller dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick),
      .btn_left(btn_left), .btn_right(btn_right), .btn_accel(btn_accel), .crash(crash),
      .car_position_x(car_position_x), .car_position_y(car_position_y), .speed(speed),
      .road_offset(road_offset), .car_visible(car_visible), .update(update)
   );

   // Reference model: plain integers, crash length counted upward, frame phase from total ticks
   localparam int M_RUN = 0, M_CRASH = 1, M_RESPAWN = 2;
   int m_x, m_speed, m_off, m_mode, m_ticks, m_crash_ticks;
   bit m_pend, m_vis, m_upd;

   task automatic model_reset();
      m_x = 120; m_speed = 0; m_off = 0; m_mode = M_RUN; m_ticks = 0;
      m_crash_ticks = 0; m_pend = 0; m_vis = 1; m_upd = 0;
   endtask

   task automatic model_step();
      int old_speed;
`ifdef CAR_BLINK_EN
      int old_mode;
      old_mode = m_mode;
`endif
      if (frame_tick) begin
         case (m_mode)
            M_RUN: begin
               if (m_pend || crash) begin
                  m_speed = 0; m_mode = M_CRASH; m_crash_ticks = 0;
               end else begin
                  old_speed = m_speed;
                  if (m_ticks % 8 == 7)
                     m_speed = btn_accel ? ((m_speed < 7) ? m_speed + 1 : 7)
                                         : ((m_speed > 0) ? m_speed - 1 : 0);
                  if (old_speed != 0 && btn_left != btn_right)
                     m_x = btn_left ? ((m_x - 2 < 0) ? 0 : m_x - 2)
                                    : ((m_x + 2 > 239) ? 239 : m_x + 2);
                  m_off = (m_off + old_speed) % 1024;
               end
            end
            M_CRASH: begin
               m_crash_ticks++;
               if (m_crash_ticks == 60) m_mode = M_RESPAWN;
            end
            default: begin
               if (m_x > 120) m_x -= ((m_x - 120) < 2) ? (m_x - 120) : 2;
               else m_x += ((120 - m_x) < 2) ? (120 - m_x) : 2;
               if (m_x == 120) m_mode = M_RUN;
            end
         endcase
`ifdef CAR_BLINK_EN
         if (m_mode == M_RUN) m_vis = 1;
         else if (old_mode != M_RUN && m_ticks % 4 == 3) m_vis = !m_vis;
`endif
         m_ticks++;
         m_pend = 0;
         m_upd = 1;
      end else begin
         m_upd = 0;
         m_pend = (m_mode == M_RUN) && (m_pend || crash);
      end
   endtask

   function automatic logic [32:0] exp_vec();
      return {m_x[7:0], 10'd400, m_speed[2:0], m_off[9:0], m_vis, m_upd};
   endfunction

   function automatic logic [32:0] obs_vec();
      return {car_position_x, car_position_y, speed, road_offset, car_visible, update};
   endfunction

   // One clock: drive at negedge, step the model at posedge, settle for sampling
   task automatic cycle(input logic t, input logic l, input logic r, input logic a,
                        input logic c, input logic rs);
      @(negedge clk);
      frame_tick = t; btn_left = l; btn_right = r; btn_accel = a; crash = c; reset = rs;
      @(posedge clk);
      if (rs) model_reset();
      else model_step();
      #1;
   endtask

   // A frame: a few idle cycles with noisy buttons, then the tick with the given buttons
   task automatic frame(input logic l, input logic r, input logic a);
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++)
         cycle(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
      cycle(1'b1, l, r, a, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      vectors++;
      if (obs_vec() !== {8'd120, 10'd400, 3'd0, 10'd0, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_values: got %h want %h", obs_vec(), {8'd120, 10'd400, 3'd0, 10'd0, 1'b1, 1'b0});
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
         miscompares++;
         $display("FAIL reset_idle: got %h want %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_accel();
      for (int i = 1; i <= 64; i++) begin
         frame(1'b0, 1'b0, 1'b1);
         vectors++;
         if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL accel tick %0d: got %h want %h", i, obs_vec(), exp_vec());
         end
         if (i == 7 || i == 8 || i == 64) begin
            vectors++;
            if (speed !== ((i == 7) ? 3'd0 : (i == 8) ? 3'd1 : 3'd7)) begin
               miscompares++;
               $display("FAIL accel_speed tick %0d: got %0d", i, speed);
            end
         end
      end
   endtask

   task automatic test_decel();
      int saved_off;
      int n;
      for (int i = 1; i <= 8; i++) frame(1'b0, 1'b0, 1'b0);
      vectors++;
      if (speed !== 3'd6) begin
         miscompares++;
         $display("FAIL decel_one_step: got %0d want 6", speed);
      end
      n = 0;
      while (m_speed != 0 && n < 64) begin
         frame(1'b0, 1'b0, 1'b0);
         n++;
         vectors++;
         if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL decel tick %0d: got %h want %h", n, obs_vec(), exp_vec());
         end
      end
      saved_off = m_off;
      for (int i = 0; i < 8; i++) frame(1'b0, 1'b0, 1'b0);
      vectors++;
      if (speed !== 3'd0 || road_offset !== saved_off[9:0]) begin
         miscompares++;
         $display("FAIL decel_floor: speed %0d offset %0d want 0 and %0d", speed, road_offset, saved_off);
      end
   endtask

   task automatic test_steer();
      int n;
      int saved_x;
      n = 0;
      while (m_x != 236 && n < 300) begin
         frame(1'b0, 1'b1, 1'(m_speed < 3));
         n++;
         vectors++;
         if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL steer_right tick %0d: got %h want %h", n, obs_vec(), exp_vec());
         end
      end
      for (int i = 0; i < 3; i++) begin
         frame(1'b0, 1'b1, 1'(m_speed < 3));
         vectors++;
         if (car_position_x !== ((i == 0) ? 8'd238 : 8'd239)) begin
            miscompares++;
            $display("FAIL steer_right_clamp step %0d: got %0d", i, car_position_x);
         end
      end
      for (int i = 0; i < 5; i++) begin
         frame(1'b1, 1'b1, 1'(m_speed < 3));
         vectors++;
         if (car_position_x !== 8'd239) begin
            miscompares++;
            $display("FAIL steer_both step %0d: got %0d want 239", i, car_position_x);
         end
      end
      for (int i = 0; i < 130; i++) begin
         frame(1'b1, 1'b0, 1'(m_speed < 3));
         vectors++;
         if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL steer_left tick %0d: got %h want %h", i, obs_vec(), exp_vec());
         end
      end
      vectors++;
      if (car_position_x !== 8'd0) begin
         miscompares++;
         $display("FAIL steer_left_clamp: got %0d want 0", car_position_x);
      end
      n = 0;
      while (m_speed != 0 && n < 40) begin
         frame(1'b1, 1'b0, 1'b0);
         n++;
      end
      saved_x = m_x;
      for (int i = 0; i < 8; i++) frame(1'b1, 1'b0, 1'b0);
      vectors++;
      if (car_position_x !== saved_x[7:0] || speed !== 3'd0) begin
         miscompares++;
         $display("FAIL steer_at_rest: x %0d speed %0d want %0d and 0", car_position_x, speed, saved_x);
      end
   endtask

   task automatic test_offset_wrap();
      int prev_off;
      int old_speed;
      bit wrapped;
      wrapped = 0;
      for (int i = 0; i < 600 && !wrapped; i++) begin
         prev_off = m_off;
         old_speed = m_speed;
         frame(1'b0, 1'b0, 1'b1);
         if (prev_off + old_speed >= 1024) wrapped = 1;
         vectors++;
         if (road_offset !== 10'((prev_off + old_speed) % 1024) || obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL offset tick %0d: got %0d want %0d", i, road_offset, (prev_off + old_speed) % 1024);
         end
      end
      vectors++;
      if (wrapped !== 1'b1) begin
         miscompares++;
         $display("FAIL offset_wrap_seen: got %0d want 1", wrapped);
      end
      // update pulses: single tick, idle, then back-to-back ticks
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (update !== 1'b1) begin miscompares++; $display("FAIL update_after_tick: got %0d want 1", update); end
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (update !== 1'b0) begin miscompares++; $display("FAIL update_idle: got %0d want 0", update); end
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         vectors++;
         if (update !== 1'b1 || obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL back_to_back %0d: got %h want %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_crash();
      int n;
      n = 0;
      while (m_x != 200 && n < 300) begin
         frame(1'b0, 1'b1, 1'(m_speed < 3));
         n++;
      end
      vectors++;
      if (car_position_x !== 8'd200 || speed === 3'd0) begin
         miscompares++;
         $display("FAIL crash_setup: x %0d speed %0d want x 200 and moving", car_position_x, speed);
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (speed !== 3'd0 || car_position_x !== 8'd200) begin
         miscompares++;
         $display("FAIL crash_entry: speed %0d x %0d want 0 and 200", speed, car_position_x);
      end
      for (int j = 1; j <= 60; j++) begin
         cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom % 3 == 0), 1'b0);
         cycle(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom % 3 == 0), 1'b0);
         vectors++;
         if (car_position_x !== 8'd200 || speed !== 3'd0 || obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL crash_hold tick %0d: got %h want %h", j, obs_vec(), exp_vec());
         end
      end
      for (int k = 1; k <= 40; k++) begin
         if (k == 40) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         cycle(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
         vectors++;
         if (car_position_x !== 8'(200 - 2 * k) || speed !== 3'd0) begin
            miscompares++;
            $display("FAIL respawn step %0d: x %0d want %0d", k, car_position_x, 200 - 2 * k);
         end
      end
      for (int i = 0; i < 16; i++) begin
         frame(1'b0, 1'b1, 1'b1);
         vectors++;
         if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL back_in_run tick %0d: got %h want %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_reset_mid();
      int saved_x;
      for (int i = 0; i < 16; i++) frame(1'b0, 1'b1, 1'b1);
      saved_x = m_x;
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      vectors++;
      if (speed !== 3'd0 || car_position_x !== saved_x[7:0]) begin
         miscompares++;
         $display("FAIL crash_on_tick: speed %0d x %0d want 0 and %0d", speed, car_position_x, saved_x);
      end
      for (int i = 0; i < 62; i++) frame(1'b1, 1'b0, 1'b1);
      vectors++;
      if (car_position_x !== 8'(saved_x - 4) || obs_vec() !== exp_vec()) begin
         miscompares++;
         $display("FAIL respawn_before_reset: x %0d want %0d", car_position_x, saved_x - 4);
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      vectors++;
      if (obs_vec() !== {8'd120, 10'd400, 3'd0, 10'd0, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_mid: got %h want %h", obs_vec(), {8'd120, 10'd400, 3'd0, 10'd0, 1'b1, 1'b0});
      end
      for (int i = 1; i <= 8; i++) begin
         frame(1'b0, 1'b0, 1'b1);
         vectors++;
         if (speed !== ((i == 8) ? 3'd1 : 3'd0)) begin
            miscompares++;
            $display("FAIL run_after_reset tick %0d: speed %0d", i, speed);
         end
      end
   endtask

   task automatic test_random();
      logic rs;
      for (int i = 0; i < 3000; i++) begin
         rs = 1'($urandom % 700 == 0);
         cycle(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom % 4 != 0),
               1'($urandom % 40 == 0), rs);
         vectors++;
         if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL random cycle %0d: got %h want %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_accel();
      test_decel();
      test_steer();
      test_offset_wrap();
      test_crash();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
